// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates a single active-low column, samples the
// rows, debounces the full 16-key image across scans and queues one code per
// new press into a small FIFO read through a valid/ready handshake.
module keypad_scanner #(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       overflow,
  output logic       any_pressed
);

  localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned StbW = $clog2(DEBOUNCE_SCANS);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  localparam logic [SetW-1:0] SetLast  = SetW'(SETTLE_CYCLES - 1);
  localparam logic [StbW-1:0] StbMax   = StbW'(DEBOUNCE_SCANS - 1);
  localparam logic [CntW-1:0] FifoFull = CntW'(FIFO_DEPTH);

  localparam logic [1:0] StSettle = 2'd0;
  localparam logic [1:0] StSample = 2'd1;
  localparam logic [1:0] StEval   = 2'd2;
  localparam logic [1:0] StPush   = 2'd3;

  // Scanner / debouncer state
  logic [1:0]      state_q, state_d;
  logic [1:0]      col_q, col_d;
  logic [SetW-1:0] set_cnt_q, set_cnt_d;
  logic [15:0]     snapshot_q, snapshot_d;
  logic [15:0]     prev_snap_q, prev_snap_d;
  logic [15:0]     debounced_q, debounced_d;
  logic [15:0]     press_mask_q, press_mask_d;
  logic [StbW-1:0] stable_cnt_q, stable_cnt_d;
  logic [StbW-1:0] stable_next;
  logic [3:0]      idx_q, idx_d;

  // FIFO state
  logic [3:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic push_req, push_ok, pop, full;

  // Saturating count of consecutive identical scans, as it will be after EVAL
  always_comb begin
    stable_next = '0;
    if (snapshot_q == prev_snap_q) begin
      stable_next = (stable_cnt_q == StbMax) ? StbMax : stable_cnt_q + StbW'(1);
    end
  end

  // Scan sequencing and debounce next-state
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    set_cnt_d    = set_cnt_q;
    snapshot_d   = snapshot_q;
    prev_snap_d  = prev_snap_q;
    debounced_d  = debounced_q;
    press_mask_d = press_mask_q;
    stable_cnt_d = stable_cnt_q;
    idx_d        = idx_q;
    unique case (state_q)
      StSettle: begin
        if (set_cnt_q == SetLast) begin
          state_d = StSample;
        end else begin
          set_cnt_d = set_cnt_q + SetW'(1);
        end
      end
      StSample: begin
        snapshot_d[{col_q, 2'b00} +: 4] = ~row_n;
        set_cnt_d = '0;
        if (col_q == 2'd3) begin
          state_d = StEval;
        end else begin
          col_d   = col_q + 2'd1;
          state_d = StSettle;
        end
      end
      StEval: begin
        stable_cnt_d = stable_next;
        prev_snap_d  = snapshot_q;
        if (stable_next == StbMax) begin
          // Only rising edges of the accepted image are queued; releases just clear bits
          press_mask_d = snapshot_q & ~debounced_q;
          debounced_d  = snapshot_q;
        end else begin
          press_mask_d = '0;
        end
        idx_d   = '0;
        state_d = StPush;
      end
      StPush: begin
        if (idx_q == 4'd15) begin
          col_d     = 2'd0;
          set_cnt_d = '0;
          state_d   = StSettle;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: state_d = StSettle;
    endcase
  end

  // Scanner / debouncer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StSettle;
      col_q        <= 2'd0;
      set_cnt_q    <= '0;
      snapshot_q   <= '0;
      prev_snap_q  <= '0;
      debounced_q  <= '0;
      press_mask_q <= '0;
      stable_cnt_q <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      set_cnt_q    <= set_cnt_d;
      snapshot_q   <= snapshot_d;
      prev_snap_q  <= prev_snap_d;
      debounced_q  <= debounced_d;
      press_mask_q <= press_mask_d;
      stable_cnt_q <= stable_cnt_d;
      idx_q        <= idx_d;
    end
  end

  // FIFO handshake decode; a pop frees the slot a same-cycle push needs
  always_comb begin
    full      = (count_q == FifoFull);
    key_valid = (count_q != '0);
    pop       = key_valid & key_ready;
    push_req  = (state_q == StPush) & press_mask_q[idx_q];
    push_ok   = push_req & (~full | pop);
    overflow  = push_req & full & ~pop & ~rst;
  end

  // FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= 4'd0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        fifo_mem_q[wr_ptr_q] <= idx_q;
        wr_ptr_q             <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Output decode
  always_comb begin
    col_n       = ~(4'b0001 << col_q);
    key_code    = fifo_mem_q[rd_ptr_q];
    any_pressed = |debounced_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SETTLE_CYCLES=2, DEBOUNCE_SCANS=3, FIFO_DEPTH=4
// (scan period 29). Cycle 0 is the first cycle after reset is released.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_ready = 1'b0;
  logic [3:0]  row_n, col_n, key_code;
  logic        key_valid, overflow, any_pressed;
  logic [15:0] keys = '0;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int got_code[$];
  int got_cyc[$];
  int ovf_n = 0;
  int ovf_cyc = -1;

  typedef struct { int col; int row; int exp_code; int exp_cyc; } press_vec_t;
  typedef struct { int c; logic [3:0] col_n; } col_vec_t;
  press_vec_t pv[5];
  col_vec_t   cv[15];

  keypad_scanner #(
    .SETTLE_CYCLES (2),
    .DEBOUNCE_SCANS(3),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_n      (row_n),
    .col_n      (col_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .overflow   (overflow),
    .any_pressed(any_pressed)
  );

  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    row_n = 4'hF;
    case (col_n)
      4'b1110: row_n = ~keys[3:0];
      4'b1101: row_n = ~keys[7:4];
      4'b1011: row_n = ~keys[11:8];
      4'b0111: row_n = ~keys[15:12];
      default: row_n = 4'hF;
    endcase
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Log handshakes and overflow pulses mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid && key_ready) begin
        got_code.push_back(int'(key_code));
        got_cyc.push_back(cyc);
      end
      if (overflow) begin
        ovf_n++;
        ovf_cyc = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    keys = '0;
    key_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    got_code.delete();
    got_cyc.delete();
    ovf_n = 0;
    ovf_cyc = -1;
  endtask

  // Return #1 after the edge that starts cycle c
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    goto(c);
    @(negedge clk);
  endtask

  initial begin
    pv[0] = '{col: 1, row: 2, exp_code: 6,  exp_cyc: 78};
    pv[1] = '{col: 0, row: 0, exp_code: 0,  exp_cyc: 72};
    pv[2] = '{col: 2, row: 1, exp_code: 9,  exp_cyc: 81};
    pv[3] = '{col: 3, row: 3, exp_code: 15, exp_cyc: 87};
    pv[4] = '{col: 2, row: 2, exp_code: 10, exp_cyc: 82};

    cv[0]  = '{c: 0,  col_n: 4'b1110};
    cv[1]  = '{c: 1,  col_n: 4'b1110};
    cv[2]  = '{c: 2,  col_n: 4'b1110};
    cv[3]  = '{c: 3,  col_n: 4'b1101};
    cv[4]  = '{c: 4,  col_n: 4'b1101};
    cv[5]  = '{c: 5,  col_n: 4'b1101};
    cv[6]  = '{c: 6,  col_n: 4'b1011};
    cv[7]  = '{c: 7,  col_n: 4'b1011};
    cv[8]  = '{c: 8,  col_n: 4'b1011};
    cv[9]  = '{c: 9,  col_n: 4'b0111};
    cv[10] = '{c: 10, col_n: 4'b0111};
    cv[11] = '{c: 11, col_n: 4'b0111};
    cv[12] = '{c: 12, col_n: 4'b0111};
    cv[13] = '{c: 28, col_n: 4'b0111};
    cv[14] = '{c: 29, col_n: 4'b1110};

    // Reset mid-scan with two codes queued
    do_reset();
    keys[1] = 1'b1;
    keys[2] = 1'b1;
    at_neg(100);
    check("queued_before_reset", int'(key_valid), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    keys = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    at_neg(0);
    check("rst_col_n", int'(col_n), 4'b1110);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_code", int'(key_code), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_any_pressed", int'(any_pressed), 0);
    for (int i = 1; i < 15; i++) begin
      at_neg(cv[i].c);
      check($sformatf("col_n_cyc%0d", cv[i].c), int'(col_n), int'(cv[i].col_n));
    end
    check("rst_no_handshake", got_code.size(), 0);

    // Single presses: one code per hold, none repeated, release debounced
    for (int v = 0; v < 5; v++) begin
      do_reset();
      key_ready = 1'b1;
      keys[pv[v].col * 4 + pv[v].row] = 1'b1;
      at_neg(70);
      check($sformatf("k%0d_any_before", pv[v].exp_code), int'(any_pressed), 0);
      at_neg(71);
      check($sformatf("k%0d_any_after", pv[v].exp_code), int'(any_pressed), 1);
      goto(348);
      keys = '0;
      check($sformatf("k%0d_count", pv[v].exp_code), got_code.size(), 1);
      if (got_code.size() >= 1) begin
        check($sformatf("k%0d_code", pv[v].exp_code), got_code[0], pv[v].exp_code);
        check($sformatf("k%0d_cycle", pv[v].exp_code), got_cyc[0], pv[v].exp_cyc);
      end
      at_neg(418);
      check($sformatf("k%0d_any_held", pv[v].exp_code), int'(any_pressed), 1);
      at_neg(419);
      check($sformatf("k%0d_any_released", pv[v].exp_code), int'(any_pressed), 0);
      check($sformatf("k%0d_no_release_code", pv[v].exp_code), got_code.size(), 1);
    end

    // Bounce on key 9: on/off/on/off, then steady from scan 4
    do_reset();
    key_ready = 1'b1;
    keys[9] = 1'b1;
    goto(29);  keys[9] = 1'b0;
    goto(58);  keys[9] = 1'b1;
    goto(87);  keys[9] = 1'b0;
    goto(116); keys[9] = 1'b1;
    goto(290);
    check("bounce_count", got_code.size(), 1);
    if (got_code.size() >= 1) begin
      check("bounce_code", got_code[0], 9);
      check("bounce_cycle", got_cyc[0], 197);
    end

    // Simultaneous keys 12 and 3: ascending order
    do_reset();
    key_ready = 1'b1;
    keys[12] = 1'b1;
    keys[3] = 1'b1;
    goto(116);
    check("simul_count", got_code.size(), 2);
    if (got_code.size() >= 2) begin
      check("simul_first", got_code[0], 3);
      check("simul_second", got_code[1], 12);
      check("simul_first_cyc", got_cyc[0], 75);
      check("simul_second_cyc", got_cyc[1], 84);
    end

    // Overflow: five presses into a four-entry FIFO with no consumer
    do_reset();
    keys[1] = 1'b1;
    goto(87);  keys[2] = 1'b1;
    goto(174); keys[4] = 1'b1;
    goto(261); keys[8] = 1'b1;
    goto(348); keys[15] = 1'b1;
    at_neg(433);
    check("ovf_before", int'(overflow), 0);
    at_neg(434);
    check("ovf_pulse", int'(overflow), 1);
    at_neg(435);
    check("ovf_after", int'(overflow), 0);
    goto(464);
    check("ovf_pulse_count", ovf_n, 1);
    check("ovf_pulse_cycle", ovf_cyc, 434);
    check("ovf_no_handshake", got_code.size(), 0);
    key_ready = 1'b1;
    at_neg(474);
    check("ovf_drain_count", got_code.size(), 4);
    if (got_code.size() >= 4) begin
      check("ovf_drain0", got_code[0], 1);
      check("ovf_drain1", got_code[1], 2);
      check("ovf_drain2", got_code[2], 4);
      check("ovf_drain3", got_code[3], 8);
      check("ovf_drain_last_cyc", got_cyc[3], 467);
    end
    check("ovf_empty", int'(key_valid), 0);

    // Full FIFO with a pop in the same cycle as a push
    do_reset();
    keys[1] = 1'b1;
    keys[2] = 1'b1;
    keys[4] = 1'b1;
    keys[8] = 1'b1;
    goto(87);
    keys[15] = 1'b1;
    goto(173);
    key_ready = 1'b1;
    @(negedge clk);
    check("fullpop_no_ovf", int'(overflow), 0);
    check("fullpop_head", int'(key_code), 1);
    @(posedge clk);
    #1;
    key_ready = 1'b0;
    goto(200);
    check("fullpop_ovf_count", ovf_n, 0);
    check("fullpop_one_pop", got_code.size(), 1);
    key_ready = 1'b1;
    at_neg(215);
    check("fullpop_total", got_code.size(), 5);
    if (got_code.size() >= 5) begin
      check("fullpop_pop_cyc", got_cyc[0], 173);
      check("fullpop_d1", got_code[1], 2);
      check("fullpop_d2", got_code[2], 4);
      check("fullpop_d3", got_code[3], 8);
      check("fullpop_d4", got_code[4], 15);
    end
    check("fullpop_empty", int'(key_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
